// File: rtl/block_sequencer.sv
// Serialises an NWORDS-word block into a hash core (last word first), pulses
// start, then waits for completion.
// Optional wait timeout with error flag: define BLK_SEQ_TIMEOUT_EN.
module block_sequencer #(
   parameter  int DATA_W      = 32,
   parameter  int NWORDS      = 16,
   parameter  int TIMEOUT_CYC = 1024,
   localparam int CNT_W       = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NWORDS*DATA_W-1:0] data_i,
   input  logic                     start_i,
   input  logic                     first_i,
   input  logic                     core_done_i,
   output logic                     load_o,
   output logic [DATA_W-1:0]        data_o,
   output logic [CNT_W-1:0]         word_idx_o,
   output logic                     start_o,
   output logic                     init_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NWORDS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [DATA_W-1:0] word_sel;

`ifdef BLK_SEQ_TIMEOUT_EN
   localparam int              WCNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              err_q, err_d;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_MAX;
         first_q <= 1'b0;
`ifdef BLK_SEQ_TIMEOUT_EN
         wcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
`ifdef BLK_SEQ_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
`ifdef BLK_SEQ_TIMEOUT_EN
      wcnt_d  = wcnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD;
               first_d = first_i;
               cnt_d   = CNT_MAX;
            end
         end
         ST_LOAD: begin
            // Counting down to zero gives exactly NWORDS load cycles.
            if (cnt_q == '0) begin
               state_d = ST_START;
               cnt_d   = CNT_MAX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
`ifdef BLK_SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         ST_WAIT: begin
            if (core_done_i) begin
               state_d = ST_DONE;
`ifdef BLK_SEQ_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (wcnt_q == WCNT_LAST) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
`endif
            end
         end
         ST_DONE: begin
            if (!start_i) begin
               state_d = ST_IDLE;
`ifdef BLK_SEQ_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Explicit compare-select keeps non-power-of-two NWORDS free of out-of-range indexing.
   always_comb begin
      word_sel = '0;
      for (int k = 0; k < NWORDS; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            word_sel = data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      load_o     = (state_q == ST_LOAD);
      data_o     = load_o ? word_sel : '0;
      word_idx_o = load_o ? cnt_q : '0;
      start_o    = (state_q == ST_START);
      init_o     = start_o & first_q;
      busy_o     = (state_q == ST_LOAD) | (state_q == ST_START) | (state_q == ST_WAIT);
      done_o     = (state_q == ST_DONE);
`ifdef BLK_SEQ_TIMEOUT_EN
      err_o      = err_q;
`else
      err_o      = 1'b0;
`endif
   end

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer: default, 4x8-bit and single-word builds,
// with a timing-rule model checking the default instance every cycle.
module tb_block_sequencer;

   localparam int NA = 16;

   logic clk, rst_n;

   logic [NA*32-1:0] data_a;
   logic             start_a, first_a, core_done_a;
   logic             a_load, a_start, a_init, a_busy, a_done, a_err;
   logic [31:0]      a_data;
   logic [3:0]       a_idx;

   logic [31:0] data_b;
   logic        start_b, first_b, core_done_b;
   logic        b_load, b_start, b_init, b_busy, b_done, b_err;
   logic [7:0]  b_data;
   logic [1:0]  b_idx;

   logic [7:0] data_c;
   logic       start_c, first_c, core_done_c;
   logic       c_load, c_start, c_init, c_busy, c_done, c_err;
   logic [7:0] c_data;
   logic       c_idx;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] word_a [NA];

   block_sequencer u_a (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_a), .start_i(start_a),
      .first_i(first_a), .core_done_i(core_done_a), .load_o(a_load),
      .data_o(a_data), .word_idx_o(a_idx), .start_o(a_start), .init_o(a_init),
      .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
   );

   block_sequencer #(.DATA_W(8), .NWORDS(4), .TIMEOUT_CYC(8)) u_b (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_b), .start_i(start_b),
      .first_i(first_b), .core_done_i(core_done_b), .load_o(b_load),
      .data_o(b_data), .word_idx_o(b_idx), .start_o(b_start), .init_o(b_init),
      .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
   );

   block_sequencer #(.DATA_W(8), .NWORDS(1)) u_c (
      .clk_i(clk), .rst_i(rst_n), .data_i(data_c), .start_i(start_c),
      .first_i(first_c), .core_done_i(core_done_c), .load_o(c_load),
      .data_o(c_data), .word_idx_o(c_idx), .start_o(c_start), .init_o(c_init),
      .busy_o(c_busy), .done_o(c_done), .err_o(c_err)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model of instance a: m_k counts edges since the accepting edge; the
   // latency rules map m_k straight onto the expected outputs.
   bit m_act, m_done, m_first;
   int m_k;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_act = 0; m_done = 0; m_first = 0; m_k = 0;
      end else if (m_done) begin
         if (!start_a) m_done = 0;
      end else if (m_act) begin
         m_k++;
         if (m_k >= NA + 2 && core_done_a) begin
            m_act  = 0;
            m_done = 1;
         end
      end else if (start_a) begin
         m_act   = 1;
         m_k     = 0;
         m_first = first_a;
      end
   end

   always @(negedge clk) begin
      logic        e_ld, e_st;
      logic [31:0] e_idx, e_data;
      e_ld   = rst_n && m_act && (m_k <= NA - 1);
      e_st   = rst_n && m_act && (m_k == NA);
      e_idx  = e_ld ? 32'(NA - 1 - m_k) : 32'd0;
      e_data = e_ld ? word_a[e_idx] : 32'd0;
      chk("a_load", 32'(a_load), 32'(e_ld));
      chk("a_data", a_data, e_data);
      chk("a_idx", 32'(a_idx), e_idx);
      chk("a_start", 32'(a_start), 32'(e_st));
      chk("a_init", 32'(a_init), 32'(e_st && m_first));
      chk("a_busy", 32'(a_busy), 32'(rst_n && m_act));
      chk("a_done", 32'(a_done), 32'(rst_n && m_done));
      chk("a_err", 32'(a_err), 32'd0);
   end

   initial begin
      rst_n = 1'b0;
      start_a = 0; first_a = 0; core_done_a = 0;
      start_b = 0; first_b = 0; core_done_b = 0;
      start_c = 0; first_c = 0; core_done_c = 0;
      for (int k = 0; k < NA; k++) begin
         word_a[k] = 32'h1000_0000 + 32'(k);
         data_a[k*32 +: 32] = 32'h1000_0000 + 32'(k);
      end
      data_b = 32'h4433_2211;
      data_c = 8'h5A;
      step(3);
      rst_n = 1'b1;
      step(2);
      chk("rst_a_busy", 32'(a_busy), 32'd0);
      chk("rst_a_done", 32'(a_done), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd0);
      chk("rst_c_busy", 32'(c_busy), 32'd0);

      // reset in the 5th load cycle, then reload from word 15
      start_a = 1; first_a = 1;
      step(5);
      chk("t1_idx_k4", 32'(a_idx), 32'd11);
      chk("t1_data_k4", a_data, 32'h1000_000B);
      rst_n = 1'b0;
      #1;
      chk("t1_async_load", 32'(a_load), 32'd0);
      chk("t1_async_busy", 32'(a_busy), 32'd0);
      chk("t1_async_data", a_data, 32'd0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("t2_first_word", a_data, 32'h1000_000F);
      chk("t2_first_idx", 32'(a_idx), 32'd15);
      step(15);
      chk("t2_last_word", a_data, 32'h1000_0000);
      chk("t2_last_idx", 32'(a_idx), 32'd0);
      step(1);
      chk("t2_start", 32'(a_start), 32'd1);
      chk("t2_init", 32'(a_init), 32'd1);
      step(5);
      core_done_a = 1;
      step(1);
      core_done_a = 0;
      chk("t2_done", 32'(a_done), 32'd1);
      step(3);
      chk("t2_done_hold", 32'(a_done), 32'd1);
      start_a = 0;
      step(1);
      chk("t2_done_clear", 32'(a_done), 32'd0);
      step(2);

      // second block, first_i toggled after acceptance
      first_a = 0; start_a = 1;
      step(1);
      first_a = 1;
      step(16);
      chk("t3_start", 32'(a_start), 32'd1);
      chk("t3_init", 32'(a_init), 32'd0);
      step(2);
      core_done_a = 1;
      step(1);
      core_done_a = 0; start_a = 0;
      chk("t3_done", 32'(a_done), 32'd1);
      step(1);
      chk("t3_idle", 32'(a_done), 32'd0);
      step(2);

      // core_done during LOAD and START ignored; start dropped in WAIT
      first_a = 1; start_a = 1;
      step(4);
      core_done_a = 1;
      step(1);
      core_done_a = 0;
      step(12);
      chk("t4_in_start", 32'(a_start), 32'd1);
      core_done_a = 1;
      step(1);
      core_done_a = 0;
      chk("t4_wait_busy", 32'(a_busy), 32'd1);
      chk("t4_wait_nodone", 32'(a_done), 32'd0);
      start_a = 0;
      step(2);
      core_done_a = 1;
      step(1);
      core_done_a = 0;
      chk("t4_pulse_hi", 32'(a_done), 32'd1);
      step(1);
      chk("t4_pulse_lo", 32'(a_done), 32'd0);
      chk("t4_idle_busy", 32'(a_busy), 32'd0);
      step(2);

      // 4 x 8-bit block
      start_b = 1; first_b = 1;
      step(1);
      chk("t5_w3", 32'(b_data), 32'h44);
      chk("t5_i3", 32'(b_idx), 32'd3);
      step(1);
      chk("t5_w2", 32'(b_data), 32'h33);
      step(1);
      chk("t5_w1", 32'(b_data), 32'h22);
      step(1);
      chk("t5_w0", 32'(b_data), 32'h11);
      chk("t5_i0", 32'(b_idx), 32'd0);
      step(1);
      chk("t5_start", 32'(b_start), 32'd1);
      chk("t5_init", 32'(b_init), 32'd1);
      chk("t5_noload", 32'(b_load), 32'd0);
      chk("t5_data0", 32'(b_data), 32'd0);
`ifdef BLK_SEQ_TIMEOUT_EN
      step(8);
      chk("t6_last_wait_busy", 32'(b_busy), 32'd1);
      chk("t6_last_wait_done", 32'(b_done), 32'd0);
      step(1);
      chk("t6_to_done", 32'(b_done), 32'd1);
      chk("t6_to_err", 32'(b_err), 32'd1);
      start_b = 0;
      step(1);
      chk("t6_err_clear", 32'(b_err), 32'd0);
      chk("t6_done_clear", 32'(b_done), 32'd0);
`else
      for (int i = 0; i < 100; i++) begin
         step(1);
         chk("t6_busy", 32'(b_busy), 32'd1);
         chk("t6_err", 32'(b_err), 32'd0);
      end
      core_done_b = 1;
      step(1);
      core_done_b = 0; start_b = 0;
      chk("t6_done", 32'(b_done), 32'd1);
      chk("t6_done_err", 32'(b_err), 32'd0);
      step(1);
      chk("t6_done_clear", 32'(b_done), 32'd0);
`endif
      step(2);

      // single-word block
      start_c = 1; first_c = 0;
      step(1);
      chk("t7_load", 32'(c_load), 32'd1);
      chk("t7_data", 32'(c_data), 32'h5A);
      chk("t7_idx", 32'(c_idx), 32'd0);
      step(1);
      chk("t7_start", 32'(c_start), 32'd1);
      chk("t7_init", 32'(c_init), 32'd0);
      core_done_c = 1;
      step(1);
      core_done_c = 0;
      chk("t7_nodone_from_start", 32'(c_done), 32'd0);
      core_done_c = 1;
      step(1);
      core_done_c = 0; start_c = 0;
      chk("t7_done", 32'(c_done), 32'd1);
      step(1);
      chk("t7_idle", 32'(c_busy | c_done), 32'd0);
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/block_sequencer.md
Name: block_sequencer

Overview:
Parametrised successor of the SHA-1 word sequencer.
- Takes a block of NWORDS words of DATA_W bits and serialises it, one word per cycle, into a hash core.
- Then issues a start pulse and waits for the core's completion.
- Adds multi-block message support (init/chain flag), a busy indication and an optional wait timeout with error flag.
- Sits between the AXI register bank and the hash core.

Parameters:
DATA_W, 32, width of one message word
NWORDS, 16, words per block (>=1; power of two not required)
TIMEOUT_CYC, 1024, WAIT-state cycle limit (used only with BLK_SEQ_TIMEOUT_EN)
CNT_W (localparam), max(1,$clog2(NWORDS)), word index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
data_i  in  NWORDS*DATA_W  block; word k at [k*DATA_W +: DATA_W]
start_i  in  1  level request, four-phase handshake with done_o
first_i  in  1  first block of message; sampled when start_i is accepted
core_done_i  in  1  core result valid
load_o  out  1  data_o valid for core
data_o  out  DATA_W  current word
word_idx_o  out  CNT_W  index of current word
start_o  out  1  one-cycle core start pulse
init_o  out  1  core re-initialise chaining state; only with start_o
busy_o  out  1  high in LOAD, START, WAIT
done_o  out  1  block complete
err_o  out  1  timeout error (constant 0 without macro)

Behaviour:
- Reset (rst_i=0, async):
  - state IDLE, cnt=NWORDS-1, first_q=0.
  - All outputs 0; data_o=0.
- FSM states: IDLE, LOAD, START, WAIT, DONE. All outputs decode from registered state/cnt/first_q; no combinational input-to-output path except data_i -> data_o through the mux.
- IDLE:
  - start_i=1 -> LOAD; latch first_q<=first_i; cnt<=NWORDS-1.
  - Otherwise stay in IDLE.
- LOAD:
  - load_o=1; data_o=word[cnt]; word_idx_o=cnt.
  - cnt decrements each cycle.
  - At cnt==0 -> START.
  - Exactly NWORDS load cycles; order is word NWORDS-1 first, word 0 last. No wrap: cnt reloads to NWORDS-1 on exit.
- START: start_o=1 and init_o=first_q for exactly one cycle -> WAIT.
- WAIT:
  - core_done_i=1 -> DONE.
  - core_done_i is ignored in every other state, including the cycle START is entered.
- DONE:
  - done_o=1 (err_o held if set).
  - start_i=0 -> IDLE; otherwise hold.
  - A new block requires start_i to go low and then high again.
- Latency: start_i sampled high at edge t.
  - LOAD spans cycles t+1..t+NWORDS.
  - START at t+NWORDS+1.
  - First WAIT cycle at t+NWORDS+2.
  - done_o rises the cycle after core_done_i is sampled in WAIT.
- Boundary behaviour:
  - start_i dropped mid-operation: ignored; block completes; DONE exits the next cycle (done_o is a 1-cycle pulse).
  - first_i changes after acceptance: no effect.
  - NWORDS=1: single LOAD cycle.
  - Reset mid-operation: immediate return to reset values; no start_o is emitted.
- Outside LOAD, data_o=0 and word_idx_o=0.

Optional Feature:
BLK_SEQ_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT_CYC cycles elapse without core_done_i -> DONE with err_o=1.
  - err_o clears on leaving DONE or on reset.
  - core_done_i and timeout in the same cycle: success wins, err_o=0.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - err_o tied 0.

Test Plan:
1. Reset: assert rst_i=0 during the 5th LOAD cycle -> load_o, busy_o, data_o all 0 asynchronously. After release, start_i=1 reloads from word 15.
2. Default params, word k=0x1000_0000+k, start_i=1, first_i=1:
   - load_o high 16 cycles; data_o 0x1000000F down to 0x10000000, word_idx_o 15..0.
   - Then start_o=init_o=1 for one cycle.
   - core_done_i 5 cycles later -> done_o high until start_i=0.
3. Second block with first_i=0 -> start_o pulse with init_o=0; load sequence identical.
4. core_done_i pulsed during LOAD and START -> ignored, FSM still reaches WAIT. start_i dropped in WAIT, then core_done_i -> done_o 1-cycle pulse, back to IDLE.
5. NWORDS=4, DATA_W=8, data_i=0x44332211 -> data_o 0x44,0x33,0x22,0x11 over 4 cycles; start_o in the 5th cycle after acceptance.
6. With BLK_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, no core_done_i -> done_o=err_o=1 after 8 WAIT cycles. Without the macro, busy_o stays 1 and err_o stays 0 for 100 cycles.
